// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types and defaults for the adder round-robin scheduler.
package adder_rr_scheduler_pkg;
  localparam int ADD_W       = 32;
  localparam int ADD_LAT_DEF = 4;
  localparam int MAX_IDW     = 3;   // covers up to 8 requesters

  typedef struct packed {
    logic               v;
    logic [MAX_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Client-side request/response bundle for the shared adder scheduler.
interface adder_rr_scheduler_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0]        req_cin;
  logic                hold;
  logic [N-1:0]        rsp_valid;
  logic [W-1:0]        rsp_sum;
  logic                rsp_cout;

  modport master (output req_valid, req_a, req_b, req_cin, hold,
                  input  req_ready, rsp_valid, rsp_sum, rsp_cout);
  modport slave  (input  req_valid, req_a, req_b, req_cin, hold,
                  output req_ready, rsp_valid, rsp_sum, rsp_cout);
endinterface

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant starting at rr_ptr,
// pointer moves one past the winner on each grant.
module adder_rr_scheduler_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = IDW'((int'(rr_ptr_q) + k) % N);
        if (!gnt_vld && req[idx]) begin
          gnt_vld  = 1'b1;
          gnt_id   = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (int'(gnt_id) == N-1) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one fixed-latency pipelined adder among N requesters; a tag pipe
// follows each op through the adder and routes the result back to its owner.
module adder_rr_scheduler
  import adder_rr_scheduler_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = ADD_W,
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int IDW     = $clog2(N)
)(
  input  logic                 clk,
  input  logic                 rst_n,
  adder_rr_scheduler_if.slave  bus,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           acc;

  // Gating with rst_n keeps req_ready low while reset is asserted.
  adder_rr_scheduler_rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~bus.hold & rst_n),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (acc)
  );
  assign bus.req_ready = gnt;

  logic [W-1:0]       add_a_q, add_a_d, add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  tag_t [ADD_LAT:0]   tag_q, tag_d;
  tag_t               tag_in;
  logic [N-1:0]       rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic [15:0]        issue_cnt_q, issue_cnt_d;

  // Tag pipe is one stage longer than the adder so the tag lines up with
  // the sum in the cycle the response registers capture it.
  always_comb begin
    add_a_d   = '0;
    add_b_d   = '0;
    add_cin_d = 1'b0;
    if (acc) begin
      add_a_d   = bus.req_a[gnt_id];
      add_b_d   = bus.req_b[gnt_id];
      add_cin_d = bus.req_cin[gnt_id];
    end
    tag_in.v    = acc;
    tag_in.id   = MAX_IDW'(gnt_id);
    tag_d       = {tag_q[ADD_LAT-1:0], tag_in};
    rsp_valid_d = tag_q[ADD_LAT].v ? (N'(1) << tag_q[ADD_LAT].id) : '0;
    rsp_sum_d   = add_sum;
    rsp_cout_d  = add_cout;
    issue_cnt_d = issue_cnt_q + {15'b0, (acc && issue_cnt_q != 16'hFFFF)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_comb begin
    busy = |rsp_valid_q;
    for (int k = 0; k <= ADD_LAT; k++) busy = busy | tag_q[k].v;
  end

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_cin       = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign issue_cnt     = issue_cnt_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler with a behavioural ADD_LAT-deep adder.
module tb_adder_rr_scheduler;
  localparam int N = 4, W = 32, ADD_LAT = 4, IDW = 2;

  logic gclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 gclk = ~gclk;

  adder_rr_scheduler_if #(.N(N), .W(W)) bus ();
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout, busy;
  logic [15:0]  issue_cnt;

  adder_rr_scheduler #(.N(N), .W(W), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
    .clk(gclk), .rst_n(rst_n), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  // Shared adder: result visible ADD_LAT edges after operands appear.
  logic [W:0] apipe [ADD_LAT];
  always_ff @(posedge gclk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int k = 1; k < ADD_LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[ADD_LAT-1][W-1:0];
  assign add_cout = apipe[ADD_LAT-1][W];

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       cout;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  int   gnt_log[$];
  int   cyc = 0;
  int   m_ptr = 0;
  logic [15:0] m_cnt = '0;

  always_ff @(posedge gclk) cyc <= cyc + 1;

  always @(negedge gclk) begin
    logic [N-1:0] eg;
    logic [W:0]   s;
    exp_t         e;
    int           gi, idx;
    if (!rst_n) begin
      sb.delete();
      m_ptr = 0;
      m_cnt = '0;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_busy",      64'(busy),          64'(0));
      chk("rst_issue_cnt", 64'(issue_cnt),     64'(0));
      chk("rst_add_a",     64'(add_a),         64'(0));
      chk("rst_ready",     64'(bus.req_ready), 64'(0));
    end else begin
      eg = '0;
      gi = -1;
      if (!bus.hold)
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (gi < 0 && bus.req_valid[idx]) begin
            gi = idx;
            eg[idx] = 1'b1;
          end
        end
      chk("ready",     64'(bus.req_ready), 64'(eg));
      chk("busy",      64'(busy),          64'(sb.size() != 0));
      chk("issue_cnt", 64'(issue_cnt),     64'(m_cnt));
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        else begin
          e = sb.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(N'(1) << e.id));
          chk("rsp_sum",   64'(bus.rsp_sum),   64'(e.sum));
          chk("rsp_cout",  64'(bus.rsp_cout),  64'(e.cout));
          chk("rsp_lat",   64'(cyc - e.cyc),   64'(ADD_LAT + 2));
        end
      end
      if (gi >= 0) begin
        s = {1'b0, bus.req_a[gi]} + {1'b0, bus.req_b[gi]} + (W+1)'(bus.req_cin[gi]);
        e.id = gi; e.sum = s[W-1:0]; e.cout = s[W]; e.cyc = cyc;
        sb.push_back(e);
        gnt_log.push_back(gi);
        m_ptr = (gi + 1) % N;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  task automatic issue_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit ok;
    bus.req_a[i] = a; bus.req_b[i] = b; bus.req_cin[i] = c;
    bus.req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge gclk);
      if (bus.req_ready[i]) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'(1));
    tick(1);
    bus.req_valid[i] = 1'b0;
  endtask

  initial begin
    int n0;
    int exp_ord[6];
    bit ok;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.hold = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // basic ops, carry out and carry in
    issue_one(0, 32'd3, 32'd2, 1'b0);
    tick(ADD_LAT + 4);
    issue_one(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue_one(2, 32'hF8E3_8E38, 32'd0, 1'b1);
    tick(ADD_LAT + 4);

    // move pointer back to 0, then all four requesting together
    issue_one(3, 32'd7, 32'd9, 1'b1);
    tick(ADD_LAT + 4);
    n0 = gnt_log.size();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 32'h1000_0000 * (i + 1) + 32'h0123;
      bus.req_b[i] = 32'hE000_0000 + 32'(i);
      bus.req_cin[i] = 1'(i);
    end
    bus.req_valid = '1;
    tick(6);
    bus.req_valid = '0;
    chk("rr_count", 64'(gnt_log.size() - n0), 64'(6));
    if (gnt_log.size() >= n0 + 6)
      for (int k = 0; k < 6; k++) chk("rr_order", 64'(gnt_log[n0+k]), 64'(exp_ord[k]));
    tick(ADD_LAT + 4);
    chk("issue_cnt_10", 64'(issue_cnt), 64'(10));

    // hold blocks acceptance; busy tail after the last accept
    bus.hold = 1'b1;
    bus.req_a[0] = 32'd100; bus.req_b[0] = 32'd23; bus.req_cin[0] = 1'b0;
    bus.req_valid[0] = 1'b1;
    tick(3);
    chk("hold_ready", 64'(bus.req_ready), 64'(0));
    chk("hold_cnt",   64'(issue_cnt),     64'(10));
    bus.hold = 1'b0;
    @(negedge gclk);
    chk("release_ready", 64'(bus.req_ready), 64'(1));
    tick(1);
    bus.req_valid[0] = 1'b0;
    tick(ADD_LAT + 1);
    chk("busy_tail_hi", 64'(busy), 64'(1));
    tick(1);
    chk("busy_tail_lo", 64'(busy), 64'(0));

    // reset mid-flight drops everything
    for (int i = 0; i < 3; i++) begin
      bus.req_a[i] = 32'(i + 5); bus.req_b[i] = 32'(i * 3); bus.req_cin[i] = 1'b1;
    end
    bus.req_valid = 4'b0111;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge gclk);
      if (bus.req_ready != '0) begin ok = 1'b1; break; end
    end
    chk("rst_accept_timeout", 64'(ok), 64'(1));
    tick(2);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_now_busy",  64'(busy),          64'(0));
    chk("rst_now_add_a", 64'(add_a),         64'(0));
    chk("rst_now_cnt",   64'(issue_cnt),     64'(0));
    tick(2);
    rst_n = 1'b1;
    tick(ADD_LAT + 6);
    chk("post_rst_cnt", 64'(issue_cnt), 64'(0));

    // saturation of the issue counter
    bus.req_a[0] = 32'hDEAD_BEEF; bus.req_b[0] = 32'h2152_4111; bus.req_cin[0] = 1'b1;
    bus.req_valid[0] = 1'b1;
    tick(65540);
    chk("sat_cnt", 64'(issue_cnt), 64'(16'hFFFF));
    bus.req_valid[0] = 1'b0;
    tick(ADD_LAT + 4);
    chk("sat_cnt_hold", 64'(issue_cnt), 64'(16'hFFFF));
    chk("idle_busy",    64'(busy),      64'(0));
    chk("sb_empty",     64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
